// File: rtl/p2_video_fb.sv
// P2-bus monochrome framebuffer: dual-port VRAM, ctrl/status register and raster scan-out.
// Bus access: wait_n low 2 cycles, held in DONE until go_n releases; video outputs lag counters by 1 cycle.
module p2_video_fb #(
  parameter int ADDR_W   = 17,
  parameter int WORD_W   = 16,
  parameter int H_ACTIVE = 1152,
  parameter int H_FP     = 40,
  parameter int H_SYNC   = 128,
  parameter int H_BP     = 216,
  parameter int V_ACTIVE = 900,
  parameter int V_FP     = 2,
  parameter int V_SYNC   = 4,
  parameter int V_BP     = 31,
  parameter int SYNC_POL = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] addr,
  input  logic              decode,
  input  logic              decode_ctl,
  input  logic              go_n,
  input  logic              wel_n,
  input  logic              weu_n,
  input  logic [WORD_W-1:0] datai,
  output logic [WORD_W-1:0] datao,
  output logic              wait_n,
  output logic              pixel,
  output logic              hsync,
  output logic              vsync,
  output logic              blank,
  output logic              irq
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL + 1);
  localparam int VW      = $clog2(V_TOTAL + 1);
  localparam int AW      = ADDR_W - 1;
  localparam int LANE    = WORD_W / 2;
  localparam int PB      = $clog2(WORD_W);

  localparam logic [HW-1:0] H_ACT        = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_LAST       = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_FETCH_WRAP = HW'(H_TOTAL - 2);
  localparam logic [HW-1:0] H_FETCH_LIM  = HW'(H_ACTIVE - 2);
  localparam logic [HW-1:0] HS_BEG       = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END       = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_ACT        = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_LAST       = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT_LAST   = VW'(V_ACTIVE - 1);
  localparam logic [VW-1:0] VS_BEG       = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END       = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [PB-1:0] W_FETCH      = PB'(WORD_W - 2);
  localparam logic          SYNC_HI      = (SYNC_POL != 0);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} bus_state_t;

  bus_state_t        state;
  logic [AW-1:0]     lat_addr;
  logic              lat_ctl;
  logic              lat_sts;
  logic              lat_wel_n;
  logic              lat_weu_n;
  logic [WORD_W-1:0] lat_dat;
  logic [WORD_W-1:0] ctl_rd;
  logic [2:0]        ctrl;

  logic [WORD_W-1:0] mem [1 << AW];
  logic [WORD_W-1:0] ram_q;
  logic [WORD_W-1:0] hold_q;
  logic [WORD_W-1:0] shift_q;
  logic [AW-1:0]     scan_addr;
  logic              fetch_d;
  logic [HW-1:0]     h;
  logic [VW-1:0]     v;

  logic active, in_vblank, hs_win, vs_win, next_line_active, fetch;
  logic lat_wr, vram_acc, irq_set, irq_clr;
  logic unused_addr_lsb;

  assign unused_addr_lsb  = addr[0];
  assign active           = (h < H_ACT) && (v < V_ACT);
  assign in_vblank        = (v >= V_ACT);
  assign hs_win           = (h >= HS_BEG) && (h < HS_END);
  assign vs_win           = (v >= VS_BEG) && (v < VS_END);
  assign next_line_active = (v == V_LAST) || (v < V_ACT_LAST);
  // Prefetch two cycles ahead of each active word; word 0 of a line comes from the previous line's tail.
  assign fetch = ((v < V_ACT) && (h < H_FETCH_LIM) && (h[PB-1:0] == W_FETCH)) ||
                 ((h == H_FETCH_WRAP) && next_line_active);

  assign lat_wr   = !lat_wel_n || !lat_weu_n;
  assign vram_acc = (state == S_BUSY) && !lat_ctl && !reset;
  assign irq_set  = (h == '0) && (v == V_ACT) && ctrl[1];
  assign irq_clr  = (state == S_BUSY) && lat_ctl && lat_sts && !lat_wel_n && lat_dat[0];

  // Bus port of the VRAM; reset suppresses the write so an aborted access leaves memory intact.
  always_ff @(posedge clk) begin
    if (vram_acc) begin
      if (!lat_wel_n) mem[lat_addr][LANE-1:0]      <= lat_dat[LANE-1:0];
      if (!lat_weu_n) mem[lat_addr][WORD_W-1:LANE] <= lat_dat[WORD_W-1:LANE];
      ram_q <= mem[lat_addr];
    end
  end

  // Scan port: a same-cycle bus write is not visible here (read-first).
  always_ff @(posedge clk) begin
    if (fetch) hold_q <= mem[scan_addr];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      wait_n    <= 1'b1;
      datao     <= '0;
      ctrl      <= '0;
      irq       <= 1'b0;
      ctl_rd    <= '0;
      lat_addr  <= '0;
      lat_ctl   <= 1'b0;
      lat_sts   <= 1'b0;
      lat_wel_n <= 1'b1;
      lat_weu_n <= 1'b1;
      lat_dat   <= '0;
    end else begin
      if (irq_set)      irq <= 1'b1;
      else if (irq_clr) irq <= 1'b0;
      case (state)
        S_IDLE: begin
          if (!go_n && (decode || decode_ctl)) begin
            lat_addr  <= addr[ADDR_W-1:1];
            lat_ctl   <= !decode;
            lat_sts   <= addr[1];
            lat_wel_n <= wel_n;
            lat_weu_n <= weu_n;
            lat_dat   <= datai;
            wait_n    <= 1'b0;
            state     <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (lat_ctl && !lat_sts && !lat_wel_n) ctrl <= lat_dat[2:0];
          ctl_rd <= lat_sts ? {in_vblank, {(WORD_W-2){1'b0}}, irq}
                            : {{(WORD_W-3){1'b0}}, ctrl};
          state  <= S_DONE;
        end
        S_DONE: begin
          wait_n <= 1'b1;
          datao  <= lat_wr ? '0 : (lat_ctl ? ctl_rd : ram_q);
          if (go_n) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      h         <= '0;
      v         <= '0;
      scan_addr <= '0;
      fetch_d   <= 1'b0;
      shift_q   <= '0;
      pixel     <= 1'b0;
      blank     <= 1'b1;
      hsync     <= !SYNC_HI;
      vsync     <= !SYNC_HI;
    end else begin
      if (h == H_LAST) begin
        h <= '0;
        v <= (v == V_LAST) ? '0 : v + 1'b1;
      end else begin
        h <= h + 1'b1;
      end
      // Rewind during the last blank line, before the wrap fetch of word 0.
      if ((v == V_LAST) && (h == '0)) scan_addr <= '0;
      else if (fetch)                 scan_addr <= scan_addr + 1'b1;
      fetch_d <= fetch;
      shift_q <= fetch_d ? hold_q : {shift_q[WORD_W-2:0], 1'b0};
      blank   <= !(active && ctrl[0]);
      pixel   <= active && ctrl[0] && (shift_q[WORD_W-1] ^ ctrl[2]);
      hsync   <= SYNC_HI ? hs_win : !hs_win;
      vsync   <= SYNC_HI ? vs_win : !vs_win;
    end
  end

endmodule

// File: tb/tb_p2_video_fb.sv
// Bench for p2_video_fb with a reduced raster; expectations come from frame-position arithmetic and a word-array VRAM model.
module tb_p2_video_fb;
  localparam int AWB = 10, HA = 32, HFP = 4, HS = 8, HBP = 4;
  localparam int VA = 6, VFP = 1, VS = 2, VBP = 2;
  localparam int HT = HA + HFP + HS + HBP;
  localparam int VT = VA + VFP + VS + VBP;
  localparam int FRAME = HT * VT;
  localparam int WPL = HA / 16;
  localparam int WORDS = 1 << (AWB - 1);

  logic clk = 1'b0;
  logic reset;
  logic [AWB-1:0] addr;
  logic decode, decode_ctl, go_n, wel_n, weu_n;
  logic [15:0] datai, datao;
  logic wait_n, pixel, hsync, vsync, blank, irq;

  int checks = 0, errors = 0;
  int cyc;
  logic [15:0] model [WORDS];
  bit [2:0] ctrl_m;

  always #5 clk = ~clk;
  always @(posedge clk) if (reset) cyc <= 0; else cyc <= cyc + 1;

  p2_video_fb #(.ADDR_W(AWB), .WORD_W(16), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP), .SYNC_POL(0)) dut (
    .clk(clk), .reset(reset), .addr(addr), .decode(decode), .decode_ctl(decode_ctl),
    .go_n(go_n), .wel_n(wel_n), .weu_n(weu_n), .datai(datai), .datao(datao),
    .wait_n(wait_n), .pixel(pixel), .hsync(hsync), .vsync(vsync), .blank(blank), .irq(irq));

  function automatic int vpos(input int c);
    return (c % FRAME) / HT;
  endfunction

  function automatic int next_at(input int now, input int pos);
    int c;
    c = now - (now % FRAME) + pos;
    if (c <= now + 8) c += FRAME;
    return c;
  endfunction

  // One complete bus cycle; returns read data, cycles wait_n was low, and the cycle index of BUSY.
  task automatic bus(input bit ctl, input logic [AWB-1:0] a, input logic [15:0] d, input bit wl,
                     input bit wu, output logic [15:0] rd, output int lo, output int bc);
    @(negedge clk);
    addr = a; decode = !ctl; decode_ctl = ctl; go_n = 1'b0; wel_n = wl; weu_n = wu; datai = d;
    lo = 0; bc = -1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (wait_n) break;
      if (lo == 0) bc = cyc;
      lo++;
    end
    rd = datao;
    go_n = 1'b1; decode = 1'b0; decode_ctl = 1'b0; wel_n = 1'b1; weu_n = 1'b1;
  endtask

  task automatic wait_cyc(input int target);
    int i;
    i = 0;
    while (cyc != target && i < 4 * FRAME) begin
      @(negedge clk);
      i++;
    end
    checks++;
    if (cyc != target) begin errors++; $display("FAIL wait_cyc: reached %0d required %0d", cyc, target); end
  endtask

  task automatic test_reset;
    reset = 1'b1; addr = '0; decode = 1'b0; decode_ctl = 1'b0; go_n = 1'b1;
    wel_n = 1'b1; weu_n = 1'b1; datai = '0; ctrl_m = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    checks++; if (wait_n !== 1'b1) begin errors++; $display("FAIL reset_wait_n: got %b want 1", wait_n); end
    checks++; if (datao !== 16'h0) begin errors++; $display("FAIL reset_datao: got %h want 0000", datao); end
    checks++; if (blank !== 1'b1) begin errors++; $display("FAIL reset_blank: got %b want 1", blank); end
    checks++; if (pixel !== 1'b0) begin errors++; $display("FAIL reset_pixel: got %b want 0", pixel); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b want 0", irq); end
    checks++; if (hsync !== 1'b1) begin errors++; $display("FAIL reset_hsync: got %b want 1", hsync); end
    checks++; if (vsync !== 1'b1) begin errors++; $display("FAIL reset_vsync: got %b want 1", vsync); end
  endtask

  task automatic test_vram_rw;
    logic [15:0] rd, d, d2;
    int lo, bc, w, l;
    logic [AWB-1:0] a;
    bus(0, 10'h010, 16'hA5C3, 0, 0, rd, lo, bc); model[8] = 16'hA5C3;
    checks++; if (lo != 2) begin errors++; $display("FAIL wr_wait_lo: got %0d want 2", lo); end
    checks++; if (rd !== 16'h0) begin errors++; $display("FAIL wr_datao: got %h want 0000", rd); end
    bus(0, 10'h010, 16'h0, 1, 1, rd, lo, bc);
    checks++; if (lo != 2) begin errors++; $display("FAIL rd_wait_lo: got %0d want 2", lo); end
    checks++; if (rd !== 16'hA5C3) begin errors++; $display("FAIL rd_full: got %h want a5c3", rd); end
    bus(0, 10'h010, 16'hFF00, 1, 0, rd, lo, bc); model[8][15:8] = 8'hFF;
    bus(0, 10'h010, 16'h0, 1, 1, rd, lo, bc);
    checks++; if (rd !== 16'hFFC3) begin errors++; $display("FAIL rd_upper_only: got %h want ffc3", rd); end
    for (int k = 0; k < 12; k++) begin
      w = $urandom_range(0, WORDS - 1);
      a = AWB'(w * 2 + $urandom_range(0, 1));
      d = 16'($urandom); d2 = 16'($urandom); l = $urandom_range(0, 3);
      bus(0, a, d, 0, 0, rd, lo, bc); model[w] = d;
      bus(0, a, d2, l[0], l[1], rd, lo, bc);
      if (l[0] == 0) model[w][7:0] = d2[7:0];
      if (l[1] == 0) model[w][15:8] = d2[15:8];
      bus(0, a, 16'h0, 1, 1, rd, lo, bc);
      checks++;
      if (rd !== model[w]) begin errors++; $display("FAIL rd_random w=%0d lanes=%0d: got %h want %h", w, l, rd, model[w]); end
    end
  endtask

  task automatic test_ctrl_regs;
    logic [15:0] rd, exp;
    int lo, bc;
    bus(1, 10'h000, 16'hFFF9, 0, 0, rd, lo, bc);
    bus(1, 10'h000, 16'h0, 1, 1, rd, lo, bc);
    checks++; if (rd !== 16'h0001) begin errors++; $display("FAIL ctrl_rd_a: got %h want 0001", rd); end
    bus(1, 10'h000, 16'hFFFC, 0, 0, rd, lo, bc);
    bus(1, 10'h000, 16'h0, 1, 1, rd, lo, bc);
    checks++; if (rd !== 16'h0004) begin errors++; $display("FAIL ctrl_rd_b: got %h want 0004", rd); end
    bus(1, 10'h000, 16'h0007, 1, 0, rd, lo, bc);
    bus(1, 10'h000, 16'h0, 1, 1, rd, lo, bc);
    checks++; if (rd !== 16'h0004) begin errors++; $display("FAIL ctrl_upper_lane: got %h want 0004", rd); end
    bus(1, 10'h002, 16'h0, 1, 1, rd, lo, bc);
    exp = {(vpos(bc) >= VA), 15'h0};
    checks++; if (rd !== exp) begin errors++; $display("FAIL status_rd: got %h want %h", rd, exp); end
    bus(1, 10'h000, 16'h0, 0, 0, rd, lo, bc); ctrl_m = '0;
  endtask

  task automatic test_scanout;
    logic [15:0] rd, wd;
    logic [3:0] obs, exp;
    int lo, bc, p, h, v, hs_cnt, vs_cnt;
    bit act;
    bit [2:0] modes [3];
    modes[0] = 3'b001; modes[1] = 3'b101; modes[2] = 3'b000;
    model[0] = 16'h8001;
    bus(0, 10'h000, 16'h8001, 0, 0, rd, lo, bc);
    for (int w = 1; w < WPL * VA; w++) begin
      model[w] = 16'($urandom);
      bus(0, AWB'(w * 2), model[w], 0, 0, rd, lo, bc);
    end
    for (int m = 0; m < 3; m++) begin
      bus(1, 10'h000, {13'h0, modes[m]}, 0, 0, rd, lo, bc); ctrl_m = modes[m];
      repeat (4) @(negedge clk);
      wait_cyc(next_at(cyc, 0));
      hs_cnt = 0; vs_cnt = 0;
      for (int k = 0; k < FRAME; k++) begin
        p = (cyc + FRAME - 1) % FRAME; h = p % HT; v = p / HT;
        act = (h < HA) && (v < VA) && ctrl_m[0];
        wd = model[(v * WPL + h / 16) % WORDS];
        exp = {act && (wd[15 - h % 16] ^ ctrl_m[2]), !act,
               !(h >= HA + HFP && h < HA + HFP + HS), !(v >= VA + VFP && v < VA + VFP + VS)};
        obs = {pixel, blank, hsync, vsync};
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL scan mode=%0d h=%0d v=%0d {pix,blank,hs,vs}: got %b want %b", m, h, v, obs, exp); end
        if (!hsync) hs_cnt++;
        if (!vsync) vs_cnt++;
        @(negedge clk);
      end
      checks++; if (hs_cnt != HS * VT) begin errors++; $display("FAIL hsync_count: got %0d want %0d", hs_cnt, HS * VT); end
      checks++; if (vs_cnt != VS * HT) begin errors++; $display("FAIL vsync_count: got %0d want %0d", vs_cnt, VS * HT); end
    end
  endtask

  task automatic test_irq;
    logic [15:0] rd;
    int lo, bc, t;
    wait_cyc(next_at(cyc, 0));
    bus(1, 10'h000, 16'h0003, 0, 0, rd, lo, bc); ctrl_m = 3'b011;
    t = next_at(cyc, VA * HT);
    wait_cyc(t);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_before_set: got %b want 0", irq); end
    @(negedge clk);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_rise: got %b want 1", irq); end
    bus(1, 10'h002, 16'h0, 1, 1, rd, lo, bc);
    checks++; if (rd !== 16'h8001) begin errors++; $display("FAIL status_irq: got %h want 8001", rd); end
    bus(1, 10'h002, 16'h0001, 0, 0, rd, lo, bc);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_clear: got %b want 0", irq); end
    t = next_at(cyc, VA * HT);
    wait_cyc(t - 2);
    bus(1, 10'h002, 16'h0001, 0, 0, rd, lo, bc);
    checks++; if (bc != t) begin errors++; $display("FAIL clr_on_set_timing: busy at %0d want %0d", bc, t); end
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL set_wins: got %b want 1", irq); end
    bus(1, 10'h000, 16'h0001, 0, 0, rd, lo, bc); ctrl_m = 3'b001;
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL pending_kept: got %b want 1", irq); end
    bus(1, 10'h002, 16'h0001, 0, 0, rd, lo, bc);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_clear2: got %b want 0", irq); end
    t = next_at(cyc, VA * HT);
    wait_cyc(t + 2);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_disabled: got %b want 0", irq); end
  endtask

  task automatic test_reset_mid_write;
    logic [15:0] rd;
    int lo, bc;
    bus(0, 10'd40, 16'h1234, 0, 0, rd, lo, bc); model[20] = 16'h1234;
    @(negedge clk);
    addr = 10'd40; decode = 1'b1; go_n = 1'b0; wel_n = 1'b0; weu_n = 1'b0; datai = 16'hBEEF;
    @(negedge clk);
    checks++; if (wait_n !== 1'b0) begin errors++; $display("FAIL busy_wait_n: got %b want 0", wait_n); end
    reset = 1'b1;
    @(negedge clk);
    checks++; if (wait_n !== 1'b1) begin errors++; $display("FAIL abort_wait_n: got %b want 1", wait_n); end
    checks++; if (blank !== 1'b1) begin errors++; $display("FAIL abort_blank: got %b want 1", blank); end
    reset = 1'b0; go_n = 1'b1; decode = 1'b0; wel_n = 1'b1; weu_n = 1'b1; ctrl_m = '0;
    bus(0, 10'd40, 16'h0, 1, 1, rd, lo, bc);
    checks++; if (lo != 2) begin errors++; $display("FAIL post_abort_wait_lo: got %0d want 2", lo); end
    checks++; if (rd !== model[20]) begin errors++; $display("FAIL abort_no_write: got %h want %h", rd, model[20]); end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_vram_rw();
    test_ctrl_regs();
    test_scanout();
    test_irq();
    test_reset_mid_write();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/p2_video_fb.md
Name: p2_video_fb

Overview:
- Parametrised successor to the Sun-2 monochrome framebuffer: bus-slave VRAM plus a control/status register and a raster scan-out engine.
- Scan-out reads the second port of the dual-port VRAM and serialises words to 1-bit pixels with hsync/vsync/blank.
- Sits on the P2 bus beside the CPU; defaults give 1152x900, 128 KB at 0x0070_0000.

Parameters:
- ADDR_W, 17: VRAM byte-address width; depth = 2^(ADDR_W-1) words.
- WORD_W, 16: bus/VRAM word width; must be 16 (two byte lanes).
- H_ACTIVE, 1152: visible pixels per line; a multiple of WORD_W.
- H_FP, 40 / H_SYNC, 128 / H_BP, 216: horizontal porch/sync pixel counts.
- V_ACTIVE, 900: visible lines.
- V_FP, 2 / V_SYNC, 4 / V_BP, 31: vertical porch/sync line counts.
- SYNC_POL, 0: 0 = syncs active-low, 1 = active-high.

Ports:
- clk  in  1  pixel/system clock.
- reset  in  1  synchronous, active-high.
- addr  in  ADDR_W  byte address; addr[ADDR_W-1:1] is the word address; addr[1] selects the ctrl register.
- decode  in  1  VRAM select.
- decode_ctl  in  1  ctrl/status select.
- go_n  in  1  bus cycle strobe, active-low.
- wel_n  in  1  lower-byte write enable, active-low.
- weu_n  in  1  upper-byte write enable, active-low.
- datai  in  WORD_W  write data.
- datao  out  WORD_W  read data.
- wait_n  out  1  low = access not complete.
- pixel  out  1  video bit; 1 = black.
- hsync  out  1  horizontal sync.
- vsync  out  1  vertical sync.
- blank  out  1  high outside the active area, or when video is disabled.
- irq  out  1  vblank interrupt, level.

Behaviour:
- Reset values:
  - datao = 0, wait_n = 1, irq = 0, pixel = 0, blank = 1.
  - hsync and vsync inactive; h and v counters = 0.
  - ctrl = 0, vram address counter = 0.
  - An access in progress is aborted; VRAM contents are unchanged.
- Bus FSM, states IDLE -> BUSY -> DONE -> IDLE:
  - IDLE: on go_n=0 with (decode|decode_ctl), latch addr/strobes, drive wait_n=0, go to BUSY. Both selects asserted: decode wins.
  - BUSY (1 cycle):
    - Writes: each byte lane is written independently when its enable is low.
    - VRAM reads: synchronous, latency 1.
    - Next state DONE.
  - DONE:
    - wait_n=1; datao holds read data, or 0 for writes.
    - Stay in DONE until go_n=1, then IDLE.
    - Exactly one write per bus cycle, even if go_n is held.
- Ctrl register (decode_ctl, addr[1]=0):
  - bit0 video_en, bit1 irq_en, bit2 invert.
  - Reads return these bits; bits [15:3] read 0.
- Status register (addr[1]=1):
  - Read returns bit15 = in_vblank, bit0 = irq.
  - Writing bit0=1 clears irq.
- Timing counters:
  - h counts 0..H_TOTAL-1; v advances when h wraps, 0..V_TOTAL-1.
  - H_TOTAL = sum of the horizontal params; V_TOTAL likewise.
  - The counters run whenever reset is low, regardless of video_en, so the monitor stays locked.
- Active area: h < H_ACTIVE and v < V_ACTIVE.
- Sync windows:
  - hsync active for H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC.
  - vsync active for the analogous v range.
- Fetch engine:
  - A VRAM port-1 read is issued 2 cycles before the first pixel of each active word, including across line wrap.
  - H_TOTAL-H_ACTIVE >= 2 is required.
  - The scan address counter increments per fetch, resets to 0 at v = V_TOTAL-1 end-of-frame, and uses no multiplier.
  - Word data lands in a holding reg, which is loaded into a shift reg at the word's first pixel; pixels shift MSB first.
- Output alignment:
  - pixel, blank, hsync and vsync are registered together, one cycle after the counters.
  - pixel = (shift MSB XOR invert) AND NOT blank.
  - When video_en=0: blank=1, pixel=0.
- Collision: a bus write and a scan read of the same word in the same cycle give the scan the old data (read-first).
- Interrupt:
  - in_vblank = v >= V_ACTIVE.
  - irq sets at h=0, v=V_ACTIVE when irq_en=1.
  - A clear write coinciding with a set: set wins.
  - Clearing irq_en does not clear a pending irq.

Test Plan:
- Reset then idle 10 cycles -> wait_n=1, datao=0, blank=1, pixel=0, irq=0, hsync/vsync high (SYNC_POL=0).
- VRAM write 0xA5C3 to byte addr 0x00010 with both enables low, then read -> wait_n low exactly 2 cycles; read returns 0xA5C3. Upper-only write of 0xFF00 -> read returns 0xFFC3.
- Ctrl write 0x0001, word 0 = 0x8001 -> first line pixels: pixel 0 = 1, pixels 1..14 = 0, pixel 15 = 1, all one cycle after h=0..15. Set invert -> complement. Disable video -> blank=1.
- Full frame with defaults -> hsync low 128 cycles per line starting at h=1192; vsync low on lines 902..905; frame period 1536x937 cycles.
- irq_en=1 -> irq rises at v=900, h=0; status read 0x8001; write 0x0001 -> irq=0; a clear on the set cycle leaves irq=1.
- Assert reset mid-write while in BUSY -> next cycle wait_n=1, FSM IDLE; no partial write, word retains its prior value.
